// File: rtl/multi_line_buffer.sv
// Ring of NUM_LINES row buffers: rows are streamed in and committed in order, the two
// oldest committed rows are read side by side at one column, and rows retire on line_pop.
module multi_line_buffer #(
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 128,
  parameter int NUM_LINES  = 4,
  parameter int ADDR_W     = $clog2(LINE_WORDS),
  parameter int CNT_W      = $clog2(NUM_LINES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [ADDR_W:0]   cfg_line_words,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              line_done,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_col,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data0,
  output logic [DATA_W-1:0] rd_data1,
  input  logic              line_pop,
  output logic [CNT_W-1:0]  lines_avail,
  output logic              rd_ok,
  output logic              err_pop
);

  localparam int PTR_W = $clog2(NUM_LINES);
  localparam int LEN_W = ADDR_W + 1;
  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(LINE_WORDS);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_LINES - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_LINES);

  // Explicit wrap so non-power-of-two ring sizes work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if ((l == {LEN_W{1'b0}}) || (l > MAX_LEN)) begin
      return MAX_LEN;
    end else begin
      return l;
    end
  endfunction

  logic [DATA_W-1:0] row_mem_r [NUM_LINES][LINE_WORDS];
  logic [LEN_W-1:0]  len_mem_r [NUM_LINES];

  logic [PTR_W-1:0]  wr_slot_r;
  logic [PTR_W-1:0]  head_r;
  logic [ADDR_W-1:0] col_r;
  logic [LEN_W-1:0]  len_r;
  logic [CNT_W-1:0]  avail_r;
  logic              line_done_r;
  logic              rd_valid_r;
  logic [DATA_W-1:0] rd_data0_r;
  logic [DATA_W-1:0] rd_data1_r;
  logic              err_pop_r;

  logic              wr_ready_s;
  logic              rd_ok_s;
  logic              wr_fire_s;
  logic              commit_s;
  logic              pop_ok_s;
  logic              pop_err_s;
  logic              rd_fire_s;
  logic [LEN_W-1:0]  row_len_s;
  logic [PTR_W-1:0]  head_next_s;
  logic [DATA_W-1:0] rd_word0_s;
  logic [DATA_W-1:0] rd_word1_s;

  // Handshake qualification, commit detection and the two-row read mux.
  always_comb begin
    wr_ready_s  = (avail_r < FULL_CNT);
    rd_ok_s     = (avail_r >= CNT_W'(2));
    wr_fire_s   = wr_valid && wr_ready_s && !flush;
    if (col_r == {ADDR_W{1'b0}}) begin
      row_len_s = clamp_len(cfg_line_words);
    end else begin
      row_len_s = len_r;
    end
    commit_s    = wr_fire_s && ({1'b0, col_r} == (row_len_s - LEN_W'(1)));
    pop_ok_s    = line_pop && (avail_r != {CNT_W{1'b0}}) && !flush;
    pop_err_s   = line_pop && (avail_r == {CNT_W{1'b0}}) && !flush;
    rd_fire_s   = rd_en && rd_ok_s && !flush;
    head_next_s = ptr_inc(head_r);
    // Columns past a short row's length read as zero.
    if ({1'b0, rd_col} < len_mem_r[head_r]) begin
      rd_word0_s = row_mem_r[head_r][rd_col];
    end else begin
      rd_word0_s = {DATA_W{1'b0}};
    end
    if ({1'b0, rd_col} < len_mem_r[head_next_s]) begin
      rd_word1_s = row_mem_r[head_next_s][rd_col];
    end else begin
      rd_word1_s = {DATA_W{1'b0}};
    end
  end

  // Row storage and per-slot lengths; contents survive reset and flush.
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      row_mem_r[wr_slot_r][col_r] <= wr_data;
    end
    if (commit_s) begin
      len_mem_r[wr_slot_r] <= row_len_s;
    end
  end

  // Pointers, row count, read pipeline and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_slot_r   <= {PTR_W{1'b0}};
      head_r      <= {PTR_W{1'b0}};
      col_r       <= {ADDR_W{1'b0}};
      len_r       <= {LEN_W{1'b0}};
      avail_r     <= {CNT_W{1'b0}};
      line_done_r <= 1'b0;
      rd_valid_r  <= 1'b0;
      rd_data0_r  <= {DATA_W{1'b0}};
      rd_data1_r  <= {DATA_W{1'b0}};
      err_pop_r   <= 1'b0;
    end else if (flush) begin
      wr_slot_r   <= {PTR_W{1'b0}};
      head_r      <= {PTR_W{1'b0}};
      col_r       <= {ADDR_W{1'b0}};
      avail_r     <= {CNT_W{1'b0}};
      line_done_r <= 1'b0;
      rd_valid_r  <= 1'b0;
      err_pop_r   <= 1'b0;
    end else begin
      if (wr_fire_s) begin
        if (col_r == {ADDR_W{1'b0}}) begin
          len_r <= row_len_s;
        end
        if (commit_s) begin
          col_r     <= {ADDR_W{1'b0}};
          wr_slot_r <= ptr_inc(wr_slot_r);
        end else begin
          col_r <= col_r + ADDR_W'(1);
        end
      end
      if (pop_ok_s) begin
        head_r <= head_next_s;
      end
      case ({commit_s, pop_ok_s})
        2'b10:   avail_r <= avail_r + CNT_W'(1);
        2'b01:   avail_r <= avail_r - CNT_W'(1);
        default: avail_r <= avail_r;
      endcase
      line_done_r <= commit_s;
      rd_valid_r  <= rd_fire_s;
      if (rd_fire_s) begin
        rd_data0_r <= rd_word0_s;
        rd_data1_r <= rd_word1_s;
      end
      err_pop_r <= err_pop_r | pop_err_s;
    end
  end

  assign wr_ready    = wr_ready_s;
  assign rd_ok       = rd_ok_s;
  assign lines_avail = avail_r;
  assign line_done   = line_done_r;
  assign rd_valid    = rd_valid_r;
  assign rd_data0    = rd_data0_r;
  assign rd_data1    = rd_data1_r;
  assign err_pop     = err_pop_r;

endmodule

// File: tb/tb_multi_line_buffer.sv
// Scoreboard bench for multi_line_buffer: a 4-slot instance for most scenarios and a
// 3-slot instance for pointer wrap-around.
module tb_multi_line_buffer;
  localparam int DW = 32;
  localparam int LW = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b0;

  logic          flush = 1'b0;
  logic [AW:0]   cfg = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic          line_done;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_col = '0;
  logic          rd_valid;
  logic [DW-1:0] rd_data0, rd_data1;
  logic          line_pop = 1'b0;
  logic [2:0]    lines_avail;
  logic          rd_ok, err_pop;

  logic          b_flush = 1'b0;
  logic [AW:0]   b_cfg = '0;
  logic          b_wr_valid = 1'b0;
  logic          b_wr_ready;
  logic [DW-1:0] b_wr_data = '0;
  logic          b_line_done;
  logic          b_rd_en = 1'b0;
  logic [AW-1:0] b_rd_col = '0;
  logic          b_rd_valid;
  logic [DW-1:0] b_rd_data0, b_rd_data1;
  logic          b_line_pop = 1'b0;
  logic [1:0]    b_lines_avail;
  logic          b_rd_ok, b_err_pop;

  multi_line_buffer #(.DATA_W(DW), .LINE_WORDS(LW), .NUM_LINES(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .cfg_line_words(cfg),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .line_done(line_done),
    .rd_en(rd_en), .rd_col(rd_col), .rd_valid(rd_valid), .rd_data0(rd_data0),
    .rd_data1(rd_data1), .line_pop(line_pop), .lines_avail(lines_avail),
    .rd_ok(rd_ok), .err_pop(err_pop));

  multi_line_buffer #(.DATA_W(DW), .LINE_WORDS(LW), .NUM_LINES(3)) dut3 (
    .clk(clk), .rst(rst), .flush(b_flush), .cfg_line_words(b_cfg),
    .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_data(b_wr_data), .line_done(b_line_done),
    .rd_en(b_rd_en), .rd_col(b_rd_col), .rd_valid(b_rd_valid), .rd_data0(b_rd_data0),
    .rd_data1(b_rd_data1), .line_pop(b_line_pop), .lines_avail(b_lines_avail),
    .rd_ok(b_rd_ok), .err_pop(b_err_pop));

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  logic [63:0] exp_q[$];
  logic [63:0] b_exp_q[$];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Scoreboard monitors: every rd_valid pops one expected pair.
  always @(negedge clk) begin
    if (!rst) begin
      if (line_done) done_cnt++;
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL rd_unexpected: got %0h/%0h with nothing expected", rd_data0, rd_data1);
        end else begin
          chk("rd_pair", {rd_data0, rd_data1}, exp_q.pop_front());
        end
      end
      if (b_rd_valid) begin
        if (b_exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL b_rd_unexpected: got %0h/%0h with nothing expected", b_rd_data0, b_rd_data1);
        end else begin
          chk("b_rd_pair", {b_rd_data0, b_rd_data1}, b_exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    int n;
    n = 0;
    wr_data = d; wr_valid = 1'b1;
    while (!wr_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) chk("push_timeout", {63'd0, wr_ready}, 64'd1);
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic push_row(input logic [AW:0] len, input int base, input int n);
    cfg = len;
    for (int i = 0; i < n; i++) push(DW'(base + i));
  endtask

  task automatic rd(input logic [AW-1:0] col, input logic [DW-1:0] e0, input logic [DW-1:0] e1);
    rd_en = 1'b1; rd_col = col;
    exp_q.push_back({e0, e1});
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  task automatic pop1();
    line_pop = 1'b1;
    @(posedge clk); #1;
    line_pop = 1'b0;
  endtask

  task automatic b_push(input logic [DW-1:0] d);
    int n;
    n = 0;
    b_wr_data = d; b_wr_valid = 1'b1;
    while (!b_wr_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) chk("b_push_timeout", {63'd0, b_wr_ready}, 64'd1);
    @(posedge clk); #1;
    b_wr_valid = 1'b0;
  endtask

  initial begin
    int acc;
    int cnt0;
    // Asynchronous reset applied before any clock edge.
    #1 rst = 1'b1;
    #1;
    chk("reset_ready", {63'd0, wr_ready}, 64'd1);
    chk("reset_avail", {61'd0, lines_avail}, 64'd0);
    chk("reset_flags", {60'd0, rd_ok, rd_valid, err_pop, line_done}, 64'd0);
    chk("reset_data", {rd_data0, rd_data1}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Fill two rows of 4 and read them side by side.
    push_row(5'd4, 0, 8);
    cyc(1);
    chk("fill_done_cnt", 64'(done_cnt), 64'd2);
    chk("fill_avail", {61'd0, lines_avail}, 64'd2);
    chk("fill_rd_ok", {63'd0, rd_ok}, 64'd1);
    rd(4'd2, 32'd2, 32'd6);
    rd(4'd0, 32'd0, 32'd4);
    rd(4'd3, 32'd3, 32'd7);

    // Read and pop together: the read sees the pre-pop rows.
    rd_en = 1'b1; rd_col = 4'd1; line_pop = 1'b1;
    exp_q.push_back({32'd1, 32'd5});
    @(posedge clk); #1;
    rd_en = 1'b0; line_pop = 1'b0;
    chk("rdpop_avail", {61'd0, lines_avail}, 64'd1);

    // A read with fewer than two rows is refused and data holds.
    rd_en = 1'b1; rd_col = 4'd0;
    @(posedge clk); #1;
    rd_en = 1'b0;
    chk("refused_valid", {63'd0, rd_valid}, 64'd0);
    chk("refused_hold", {rd_data0, rd_data1}, {32'd1, 32'd5});

    // Short row of 2 words behind row B.
    push_row(5'd2, 100, 2);
    cyc(1);
    chk("short_avail", {61'd0, lines_avail}, 64'd2);
    rd(4'd1, 32'd5, 32'd101);

    // Commit of a new row and pop of row B in the same cycle.
    cfg = 5'd4;
    push(32'd200); push(32'd201); push(32'd202);
    wr_data = 32'd203; wr_valid = 1'b1; line_pop = 1'b1;
    @(posedge clk); #1;
    wr_valid = 1'b0; line_pop = 1'b0;
    chk("commitpop_avail", {61'd0, lines_avail}, 64'd2);
    cyc(1);
    chk("commitpop_done", 64'(done_cnt), 64'd4);
    rd(4'd3, 32'd0, 32'd203);
    rd(4'd1, 32'd101, 32'd201);

    // Drain, then a pop on an empty buffer only raises err_pop.
    pop1(); pop1();
    chk("drain_avail", {61'd0, lines_avail}, 64'd0);
    pop1();
    chk("errpop_flag", {63'd0, err_pop}, 64'd1);
    chk("errpop_avail", {61'd0, lines_avail}, 64'd0);
    chk("errpop_ready", {63'd0, wr_ready}, 64'd1);

    // cfg_line_words = 0 clamps the row to LINE_WORDS words.
    push_row(5'd0, 300, 15);
    cyc(1);
    chk("clamp_partial", {61'd0, lines_avail}, 64'd0);
    push(32'd315);
    cyc(1);
    chk("clamp_commit", {61'd0, lines_avail}, 64'd1);
    chk("clamp_done", 64'(done_cnt), 64'd5);
    push_row(5'd4, 400, 4);
    cyc(1);
    rd(4'd15, 32'd315, 32'd0);
    rd(4'd2, 32'd302, 32'd402);

    // Flush mid-row discards the partial row and clears err_pop.
    push_row(5'd4, 500, 2);
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    chk("flush_avail", {61'd0, lines_avail}, 64'd0);
    chk("flush_flags", {61'd0, err_pop, rd_ok, rd_valid}, 64'd0);
    chk("flush_ready", {63'd0, wr_ready}, 64'd1);
    push_row(5'd4, 600, 2);
    cyc(1);
    chk("flush_col_restart", {61'd0, lines_avail}, 64'd0);
    push(32'd602); push(32'd603);
    cyc(1);
    chk("flush_row_commit", {61'd0, lines_avail}, 64'd1);
    push_row(5'd4, 700, 4);
    cyc(1);
    rd(4'd0, 32'd600, 32'd700);
    rd(4'd3, 32'd603, 32'd703);

    // Backpressure: stream words 1..20 with wr_valid held high.
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    cnt0 = done_cnt;
    acc = 0;
    cfg = 5'd4; wr_data = 32'd1; wr_valid = 1'b1;
    for (int c = 0; c < 60 && acc < 16; c++) begin
      logic will;
      will = wr_ready;
      @(posedge clk); #1;
      if (will) begin acc++; wr_data = DW'(acc + 1); end
    end
    chk("bp_accepted16", 64'(acc), 64'd16);
    chk("bp_full_ready", {63'd0, wr_ready}, 64'd0);
    chk("bp_full_avail", {61'd0, lines_avail}, 64'd4);
    cyc(2);
    chk("bp_hold_ready", {63'd0, wr_ready}, 64'd0);
    line_pop = 1'b1;
    #1;
    chk("bp_no_comb_ready", {63'd0, wr_ready}, 64'd0);
    @(posedge clk); #1;
    line_pop = 1'b0;
    chk("bp_pop_ready", {63'd0, wr_ready}, 64'd1);
    chk("bp_pop_avail", {61'd0, lines_avail}, 64'd3);
    for (int c = 0; c < 60 && acc < 20; c++) begin
      logic will;
      will = wr_ready;
      @(posedge clk); #1;
      if (will) begin acc++; wr_data = DW'(acc + 1); end
    end
    wr_valid = 1'b0;
    chk("bp_accepted20", 64'(acc), 64'd20);
    chk("bp_refull_avail", {61'd0, lines_avail}, 64'd4);
    chk("bp_refull_ready", {63'd0, wr_ready}, 64'd0);
    cyc(1);
    chk("bp_done", 64'(done_cnt - cnt0), 64'd5);
    rd(4'd0, 32'd5, 32'd9);

    // Asynchronous reset mid-row, between clock edges.
    pop1(); pop1();
    push_row(5'd4, 800, 2);
    rd_en = 1'b1; rd_col = 4'd1;
    exp_q.push_back({32'd14, 32'd18});
    @(posedge clk); #1;
    rd_en = 1'b0;
    #6;
    rst = 1'b1;
    #1;
    chk("arst_valid", {63'd0, rd_valid}, 64'd0);
    chk("arst_data", {rd_data0, rd_data1}, 64'd0);
    chk("arst_avail", {61'd0, lines_avail}, 64'd0);
    chk("arst_flags", {61'd0, rd_ok, err_pop, line_done}, 64'd0);
    chk("arst_ready", {63'd0, wr_ready}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    push_row(5'd4, 900, 4);
    cyc(1);
    chk("arst_new_row", {61'd0, lines_avail}, 64'd1);

    // Three-slot ring: five rows of 2, popping whenever full.
    b_cfg = 5'd2;
    for (int r = 1; r <= 5; r++) begin
      b_push(DW'(r * 10));
      b_push(DW'(r * 10 + 1));
      if (b_lines_avail == 2'd3) begin
        b_line_pop = 1'b1;
        @(posedge clk); #1;
        b_line_pop = 1'b0;
      end
    end
    chk("wrap_avail", {62'd0, b_lines_avail}, 64'd2);
    b_rd_en = 1'b1; b_rd_col = 4'd0;
    b_exp_q.push_back({32'd40, 32'd50});
    @(posedge clk); #1;
    b_rd_col = 4'd1;
    b_exp_q.push_back({32'd41, 32'd51});
    @(posedge clk); #1;
    b_rd_en = 1'b0;

    cyc(3);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("b_scoreboard_empty", 64'(b_exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
